sram_controller: RTL

Multi-cycle memory-stage controller that bridges the pipeline's 32-bit data-memory requests to an external 16-bit synchronous-model SRAM. It performs each 32-bit access as two 16-bit half-accesses and drives `freeze`, which connects directly to the active-low `ld` (hold) input of the PC and pipeline registers so the whole pipeline stalls until the access completes. It sits in the MEM stage, directly upstream of the MEM/WB register that consumes `rdata`.

---
 rtl/sram_controller.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// sram_controller: splits each 32-bit MEM-stage access into two 16-bit
// half-accesses on a synchronous SRAM and freezes the pipeline until done.
module sram_controller #(
  parameter int unsigned PHASE_CYCLES = 2,
  parameter int unsigned SRAM_AW      = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               freeze,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               is_wr_q, is_wr_d;
  logic               last_cnt;

  // Byte-offset and bits above the SRAM word range are not used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:SRAM_AW+1], address[1:0]};

  assign last_cnt = (cnt_q == LAST_CNT);
  assign rdata    = rdata_q;
  assign freeze   = ~ready;

  // State, phase counter, latched request and read data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      is_wr_q <= is_wr_d;
    end
  end

  // Next-state logic, half-word read capture and SRAM bus outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    is_wr_d     = is_wr_q;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = ~rd_en & ~wr_en;
        if (rd_en | wr_en) begin
          word_d  = address[SRAM_AW:2];
          wdata_d = wdata;
          is_wr_d = wr_en;
          cnt_d   = '0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        sram_addr = {word_q, 1'b0};
        if (is_wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[15:0];
        end
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = S_HIGH;
          if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        sram_addr = {word_q, 1'b1};
        if (is_wr_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_q[31:16];
        end
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (!is_wr_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
